instr_prefetch_queue: RTL and testbench
=======================================

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter IW, default 8: instruction width in bits, at least OPW+1.
REQ-002 Parameter OPW, default 4: opcode field width, taken from the MSBs of the instruction.
REQ-003 Parameter DEPTH, default 4: queue entries, a power of 2 and at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 LoadIR  input  1  push request: write instruction into the tail.
REQ-007 instruction  input  IW  instruction word to push.
REQ-008 Advance  input  1  pop request: retire the current head instruction.
REQ-009 Flush  input  1  synchronous discard of all entries (branch/redirect).
REQ-010 Opcode  output  OPW  head entry bits [IW-1:IW-OPW].
REQ-011 Immediate_data  output  IW-OPW  head entry bits [IW-OPW-1:0].
REQ-012 IRValid  output  1  head entry holds a valid instruction.
REQ-013 Full  output  1  Count equals DEPTH.
REQ-014 Count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-015 Overflow  output  1  sticky flag: a push was dropped.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 Opcode and Immediate_data SHALL be driven combinationally from the head entry when IRValid is 1, and SHALL be all zeros when IRValid is 0 (never X or Z).
REQ-018 IRValid SHALL equal (Count != 0) and Full SHALL equal (Count == DEPTH), both decoded from registered state.
REQ-019 A push SHALL be accepted when LoadIR=1 and either Full=0, or Full=1 and Advance=1 in the same cycle.
REQ-020 A pop SHALL be accepted when Advance=1 and IRValid=1; Advance with IRValid=0 SHALL be ignored.
REQ-021 Latency: an instruction pushed into an empty queue at edge N SHALL appear on Opcode/Immediate_data with IRValid=1 immediately after edge N.
REQ-022 A simultaneous accepted push and pop SHALL leave Count unchanged, advance both pointers, and present the next-oldest entry at the head.
REQ-023 When the queue is empty and LoadIR=Advance=1, the pop SHALL be ignored, the push SHALL be accepted, and Count SHALL become 1.
REQ-024 A push rejected under REQ-019 (Full=1, Advance=0) SHALL be dropped, SHALL leave the queue contents unchanged, and SHALL set Overflow to 1 at that edge.
REQ-025 Overflow SHALL stay at 1 until reset or Flush.
REQ-026 When Flush=1, at the edge: Count becomes 0, head and tail become 0, and Overflow clears.
REQ-027 Flush SHALL take priority over LoadIR and Advance in the same cycle; that cycle's push and pop SHALL be discarded.
REQ-028 Entries that are not valid SHALL never be observable on the outputs.
REQ-029 Count SHALL never exceed DEPTH and SHALL never underflow below 0.

Reset
REQ-030 When reset=0, regardless of clk, the block SHALL immediately force: Count=0, head=0, tail=0, Overflow=0, IRValid=0, Full=0, Opcode=0, Immediate_data=0.
REQ-031 Buffer contents need not be cleared on reset, but are unobservable under REQ-017.
REQ-032 A reset asserted mid-operation SHALL discard all queued instructions.
REQ-033 The first push SHALL be accepted at the first rising edge after reset returns to 1.

Verification
REQ-034 Defaults, empty queue: reset, then push 8'hA5 -> next cycle Opcode=4'hA, Immediate_data=4'h5, IRValid=1, Count=1.
REQ-035 Fill and order: push 8'h11, 8'h22, 8'h33, 8'h44 -> Full=1, Count=4; then four pops -> heads read 1/1, 2/2, 3/3, 4/4 in that order, after which IRValid=0 and outputs are 0.
REQ-036 Overflow and full-bypass: with the queue full, push 8'h55 with Advance=0 -> dropped, Overflow=1, Count=4; then push 8'h66 with Advance=1 -> Count=4, head=8'h22, Overflow still 1.
REQ-037 Wrap-around: run 10 cycles of simultaneous push/pop with Count held at 2 -> FIFO order is preserved across pointer wrap and Count stays 2.
REQ-038 Flush priority: with Count=3, assert Flush, LoadIR and Advance together -> Count=0, IRValid=0, Overflow=0, and the pushed word is not present.
REQ-039 Asynchronous reset: with Count=2, drive reset=0 between clock edges -> all outputs are 0 before the next edge; after release, a push of 8'h9C reads back as 9/C.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: a small circular FIFO of instruction words whose
// head entry is split into opcode and immediate fields for the decode stage.
module instr_prefetch_queue #(
  parameter int IW    = 8,
  parameter int OPW   = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       LoadIR,
  input  logic [IW-1:0]              instruction,
  input  logic                       Advance,
  input  logic                       Flush,
  output logic [OPW-1:0]             Opcode,
  output logic [IW-OPW-1:0]          Immediate_data,
  output logic                       IRValid,
  output logic                       Full,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;
  logic          push_ok;
  logic          pop_ok;
  logic [IW-1:0] head_word;

  assign IRValid = (count != '0);
  assign Full    = (count == CW'(DEPTH));

  // A full queue may still take a push when the head retires in the same cycle.
  assign push_ok = LoadIR && (!Full || Advance);
  assign pop_ok  = Advance && IRValid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (Flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (LoadIR && !push_ok) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; unused entries are masked off at the outputs.
  always_ff @(posedge clk) begin
    if (!Flush && push_ok) mem[tail] <= instruction;
  end

  assign head_word      = mem[head];
  assign Opcode         = IRValid ? head_word[IW-1:IW-OPW] : '0;
  assign Immediate_data = IRValid ? head_word[IW-OPW-1:0] : '0;
  assign Count          = count;
  assign Overflow       = overflow;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed self-checking bench for instr_prefetch_queue with hand-computed
// expected head words, counts and flags.
module tb_instr_prefetch_queue;

  logic       clk;
  logic       reset;
  logic       LoadIR;
  logic [7:0] instruction;
  logic       Advance;
  logic       Flush;
  logic [3:0] Opcode;
  logic [3:0] Immediate_data;
  logic       IRValid;
  logic       Full;
  logic [2:0] Count;
  logic       Overflow;

  int vectors;
  int miscompares;

  instr_prefetch_queue #(.IW(8), .OPW(4), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .LoadIR         (LoadIR),
    .instruction    (instruction),
    .Advance        (Advance),
    .Flush          (Flush),
    .Opcode         (Opcode),
    .Immediate_data (Immediate_data),
    .IRValid        (IRValid),
    .Full           (Full),
    .Count          (Count),
    .Overflow       (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input logic load, input logic [7:0] instr,
                               input logic adv, input logic flush);
    LoadIR      = load;
    instruction = instr;
    Advance     = adv;
    Flush       = flush;
    @(posedge clk);
    #1;
    LoadIR  = 1'b0;
    Advance = 1'b0;
    Flush   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    LoadIR      = 1'b0;
    instruction = '0;
    Advance     = 1'b0;
    Flush       = 1'b0;

    #12;
    checkOutput("rst_count",   32'(Count), 32'd0);
    checkOutput("rst_valid",   32'(IRValid), 32'd0);
    checkOutput("rst_full",    32'(Full), 32'd0);
    checkOutput("rst_ovf",     32'(Overflow), 32'd0);
    checkOutput("rst_head",    {24'd0, Opcode, Immediate_data}, 32'h00);
    reset = 1'b1;

    // First push after reset release is visible right after the edge
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("a5_opcode", 32'(Opcode), 32'hA);
    checkOutput("a5_imm",    32'(Immediate_data), 32'h5);
    checkOutput("a5_valid",  32'(IRValid), 32'd1);
    checkOutput("a5_count",  32'(Count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("a5_pop_count", 32'(Count), 32'd0);

    // Push and pop together on an empty queue: only the push happens
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("emptypp_count", 32'(Count), 32'd1);
    checkOutput("emptypp_head",  {24'd0, Opcode, Immediate_data}, 32'h77);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("underflow_count", 32'(Count), 32'd0);

    // Fill and drain in order
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
    checkOutput("fill_full",  32'(Full), 32'd1);
    checkOutput("fill_count", 32'(Count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_head", {24'd0, Opcode, Immediate_data}, 32'(i * 8'h11));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("drain_valid", 32'(IRValid), 32'd0);
    checkOutput("drain_zero",  {24'd0, Opcode, Immediate_data}, 32'h00);
    checkOutput("drain_full",  32'(Full), 32'd0);

    // Overflow on full, then full bypass with a simultaneous pop
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("ovf_flag",  32'(Overflow), 32'd1);
    checkOutput("ovf_count", 32'(Count), 32'd4);
    checkOutput("ovf_head",  {24'd0, Opcode, Immediate_data}, 32'h11);
    applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
    checkOutput("bypass_count", 32'(Count), 32'd4);
    checkOutput("bypass_head",  {24'd0, Opcode, Immediate_data}, 32'h22);
    checkOutput("bypass_ovf",   32'(Overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("bypass_h33", {24'd0, Opcode, Immediate_data}, 32'h33);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("bypass_h44", {24'd0, Opcode, Immediate_data}, 32'h44);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("bypass_h66", {24'd0, Opcode, Immediate_data}, 32'h66);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("bypass_empty", 32'(Count), 32'd0);
    checkOutput("ovf_sticky",   32'(Overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("flush_ovf_clr", 32'(Overflow), 32'd0);

    // Steady push/pop at Count=2 across several pointer wraps
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 8'(8'h03 + k), 1'b1, 1'b0);
      checkOutput("wrap_head",  {24'd0, Opcode, Immediate_data}, 32'(8'h02 + k));
      checkOutput("wrap_count", 32'(Count), 32'd2);
    end

    // Queue now holds 0B,0C; build Count=3 with Overflow set, then flush
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0E, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0);
    checkOutput("pre_flush_ovf", 32'(Overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pre_flush_count", 32'(Count), 32'd3);
    checkOutput("pre_flush_head",  {24'd0, Opcode, Immediate_data}, 32'h0C);
    applyStimulus(1'b1, 8'hF0, 1'b1, 1'b1);
    checkOutput("flush_count", 32'(Count), 32'd0);
    checkOutput("flush_valid", 32'(IRValid), 32'd0);
    checkOutput("flush_ovf",   32'(Overflow), 32'd0);
    checkOutput("flush_zero",  {24'd0, Opcode, Immediate_data}, 32'h00);
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    checkOutput("post_flush_count", 32'(Count), 32'd1);
    checkOutput("post_flush_head",  {24'd0, Opcode, Immediate_data}, 32'h12);

    // Asynchronous reset between edges with two entries queued
    applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(Count), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_count", 32'(Count), 32'd0);
    checkOutput("arst_valid", 32'(IRValid), 32'd0);
    checkOutput("arst_full",  32'(Full), 32'd0);
    checkOutput("arst_ovf",   32'(Overflow), 32'd0);
    checkOutput("arst_head",  {24'd0, Opcode, Immediate_data}, 32'h00);
    #2;
    reset = 1'b1;
    applyStimulus(1'b1, 8'h9C, 1'b0, 1'b0);
    checkOutput("9c_opcode", 32'(Opcode), 32'h9);
    checkOutput("9c_imm",    32'(Immediate_data), 32'hC);
    checkOutput("9c_count",  32'(Count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
